// File: rtl/ctrl_pkg.sv
// ----------------------------------------------------------------------------
// ctrl_pkg
// Shared definitions for the multicycle RISC-V control unit:
//   - opcode constants for every instruction class the unit recognises
//   - alu_cmd encodings driven towards the datapath ALU
//   - phase and run/halt state enumerations
//   - decode_t: the decoder's output record, consumed by the top-level FSM
// ----------------------------------------------------------------------------
package ctrl_pkg;

    // Opcodes (instr[6:0])
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_IALU   = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_BUBBLE = 7'b0000000;

    // ALU commands. FUNCT hands the choice of operation to the datapath,
    // which decodes funct3/funct7 itself. Other codes are reserved.
    localparam logic [3:0] ALU_ADD   = 4'd0;
    localparam logic [3:0] ALU_SUB   = 4'd1;
    localparam logic [3:0] ALU_FUNCT = 4'd15;

    // One datapath instruction spans the four phases below.
    typedef enum logic [1:0] {
        PH_IF = 2'd0,
        PH_ID = 2'd1,
        PH_EX = 2'd2,
        PH_WB = 2'd3
    } phase_e;

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } state_e;

    // Decoded view of one opcode. rf_we / d_mem_we are write intents that
    // only reach the outputs during the WB phase.
    typedef struct packed {
        logic       legal;
        logic       bubble;
        logic       rf_we;
        logic       d_mem_we;
        logic       alu_src;
        logic       rf_src;
        logic       pc_src;
        logic [3:0] alu_cmd;
    } decode_t;

endpackage

// File: rtl/control_unit_fsm_if.sv
// ----------------------------------------------------------------------------
// control_unit_fsm_if
// Bundle between the control unit and the datapath.
//   opcode   : instruction opcode exported by the datapath
//   d_mem_we : data-memory write enable
//   rf_we    : register-file write enable
//   alu_src  : 0 = register B operand, 1 = immediate
//   pc_src   : 1 = PC takes PC+imm
//   rf_src   : 0 = ALU result, 1 = memory data written to the register file
//   alu_cmd  : ALU command (ctrl_pkg ALU_* encodings)
//   phase    : current phase 0..3 (IF, ID, EX, WB)
//   illegal  : sticky illegal-opcode flag
//   retired  : saturating count of retired non-bubble instructions
// Modports: master = control unit, slave = datapath.
// ----------------------------------------------------------------------------
interface control_unit_fsm_if #(
    parameter int CNT_W = 32
);
    logic [6:0]       opcode;
    logic             d_mem_we;
    logic             rf_we;
    logic             alu_src;
    logic             pc_src;
    logic             rf_src;
    logic [3:0]       alu_cmd;
    logic [1:0]       phase;
    logic             illegal;
    logic [CNT_W-1:0] retired;

    modport master (
        input  opcode,
        output d_mem_we, rf_we, alu_src, pc_src, rf_src, alu_cmd,
        output phase, illegal, retired
    );

    modport slave (
        output opcode,
        input  d_mem_we, rf_we, alu_src, pc_src, rf_src, alu_cmd,
        input  phase, illegal, retired
    );
endinterface

// File: rtl/ctrl_decoder.sv
// ----------------------------------------------------------------------------
// ctrl_decoder
// Purely combinational opcode decoder.
//   opcode : instruction opcode
//   dec    : decoded control record (legal, bubble, write intents, muxes, alu)
// Anything not listed below is illegal; the bubble opcode is legal but does
// nothing and is not counted as a retired instruction.
// ----------------------------------------------------------------------------
module ctrl_decoder
    import ctrl_pkg::*;
(
    input  logic [6:0] opcode,
    output decode_t    dec
);

    always_comb begin
        dec         = '0;
        dec.alu_cmd = ALU_ADD;
        dec.legal   = 1'b1;
        unique case (opcode)
            OP_RTYPE: begin
                dec.rf_we   = 1'b1;
                dec.alu_cmd = ALU_FUNCT;
            end
            OP_IALU: begin
                dec.rf_we   = 1'b1;
                dec.alu_src = 1'b1;
                dec.alu_cmd = ALU_FUNCT;
            end
            OP_LOAD: begin
                dec.rf_we   = 1'b1;
                dec.alu_src = 1'b1;
                dec.rf_src  = 1'b1;
            end
            OP_STORE: begin
                dec.d_mem_we = 1'b1;
                dec.alu_src  = 1'b1;
            end
            OP_BRANCH: begin
                // The datapath resolves the branch from the ALU flags, so
                // pc_src stays low here.
                dec.alu_cmd = ALU_SUB;
            end
            OP_JAL: begin
                // Link register write is not supported: jump only.
                dec.pc_src = 1'b1;
            end
            OP_BUBBLE: begin
                dec.bubble = 1'b1;
            end
            default: begin
                dec.legal = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/control_unit_fsm.sv
// ----------------------------------------------------------------------------
// control_unit_fsm
// Multicycle control unit for a RISC-V datapath. Each instruction takes four
// clk cycles (IF, ID, EX, WB). The opcode is sampled only on the edge that
// leaves IF; the decoded controls then hold for ID..WB and clear on the edge
// back into IF. Write enables are exposed during WB only, for exactly one
// cycle. An illegal opcode raises a sticky flag and halts the unit with all
// controls low and phase frozen at ID until reset.
//   clk  : system clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : control_unit_fsm_if master modport (opcode in, controls out)
// ----------------------------------------------------------------------------
module control_unit_fsm
    import ctrl_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    control_unit_fsm_if.master    bus
);

    localparam logic [CNT_W-1:0] RETIRED_MAX = {CNT_W{1'b1}};

    decode_t dec;

    state_e           state_reg;
    phase_e           phase_reg;
    logic             rf_we_reg;
    logic             d_mem_we_reg;
    logic             alu_src_reg;
    logic             pc_src_reg;
    logic             rf_src_reg;
    logic [3:0]       alu_cmd_reg;
    logic             illegal_reg;
    logic [CNT_W-1:0] retired_reg;

    // Write intents captured at decode; they are only copied onto the
    // visible enables when entering WB.
    logic             rf_we_pend_reg;
    logic             d_mem_we_pend_reg;
    // Set when the instruction in flight should bump the retired counter.
    logic             count_reg;

    ctrl_decoder u_decoder (
        .opcode (bus.opcode),
        .dec    (dec)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg         <= RUN;
            phase_reg         <= PH_IF;
            rf_we_reg         <= 1'b0;
            d_mem_we_reg      <= 1'b0;
            alu_src_reg       <= 1'b0;
            pc_src_reg        <= 1'b0;
            rf_src_reg        <= 1'b0;
            alu_cmd_reg       <= ALU_ADD;
            illegal_reg       <= 1'b0;
            retired_reg       <= '0;
            rf_we_pend_reg    <= 1'b0;
            d_mem_we_pend_reg <= 1'b0;
            count_reg         <= 1'b0;
        end else if (state_reg == RUN) begin
            unique case (phase_reg)
                PH_IF: begin
                    phase_reg <= PH_ID;
                    if (!dec.legal) begin
                        // Controls are already low here (cleared entering
                        // IF); force them anyway so HALT is self-evidently
                        // quiet.
                        state_reg         <= HALT;
                        illegal_reg       <= 1'b1;
                        alu_src_reg       <= 1'b0;
                        pc_src_reg        <= 1'b0;
                        rf_src_reg        <= 1'b0;
                        alu_cmd_reg       <= ALU_ADD;
                        rf_we_pend_reg    <= 1'b0;
                        d_mem_we_pend_reg <= 1'b0;
                        count_reg         <= 1'b0;
                    end else begin
                        alu_src_reg       <= dec.alu_src;
                        pc_src_reg        <= dec.pc_src;
                        rf_src_reg        <= dec.rf_src;
                        alu_cmd_reg       <= dec.alu_cmd;
                        rf_we_pend_reg    <= dec.rf_we;
                        d_mem_we_pend_reg <= dec.d_mem_we;
                        count_reg         <= !dec.bubble;
                    end
                end
                PH_ID: begin
                    phase_reg <= PH_EX;
                end
                PH_EX: begin
                    phase_reg    <= PH_WB;
                    rf_we_reg    <= rf_we_pend_reg;
                    d_mem_we_reg <= d_mem_we_pend_reg;
                end
                PH_WB: begin
                    phase_reg         <= PH_IF;
                    rf_we_reg         <= 1'b0;
                    d_mem_we_reg      <= 1'b0;
                    alu_src_reg       <= 1'b0;
                    pc_src_reg        <= 1'b0;
                    rf_src_reg        <= 1'b0;
                    alu_cmd_reg       <= ALU_ADD;
                    rf_we_pend_reg    <= 1'b0;
                    d_mem_we_pend_reg <= 1'b0;
                    count_reg         <= 1'b0;
                    if (count_reg && (retired_reg != RETIRED_MAX)) begin
                        retired_reg <= retired_reg + CNT_W'(1);
                    end
                end
                default: begin
                    phase_reg <= PH_IF;
                end
            endcase
        end
        // HALT: every register holds; only rst leaves this state.
    end

    assign bus.d_mem_we = d_mem_we_reg;
    assign bus.rf_we    = rf_we_reg;
    assign bus.alu_src  = alu_src_reg;
    assign bus.pc_src   = pc_src_reg;
    assign bus.rf_src   = rf_src_reg;
    assign bus.alu_cmd  = alu_cmd_reg;
    assign bus.phase    = phase_reg;
    assign bus.illegal  = illegal_reg;
    assign bus.retired  = retired_reg;

endmodule

// File: tb/tb_control_unit_fsm.sv
// ----------------------------------------------------------------------------
// tb_control_unit_fsm
// Table of literal vectors for the basic R/load/store flow, directed
// sequences for branch/JAL, bubbles, illegal halt, mid-instruction reset and
// counter saturation, then randomized opcodes against an instruction-level
// reference model.
// ----------------------------------------------------------------------------
module tb_control_unit_fsm;

    localparam int CNT_W = 4;
    localparam int RET_MAX = (1 << CNT_W) - 1;

    localparam logic [6:0] R_OP   = 7'b0110011;
    localparam logic [6:0] IA_OP  = 7'b0010011;
    localparam logic [6:0] LD_OP  = 7'b0000011;
    localparam logic [6:0] ST_OP  = 7'b0100011;
    localparam logic [6:0] BR_OP  = 7'b1100011;
    localparam logic [6:0] JAL_OP = 7'b1101111;
    localparam logic [6:0] BUB_OP = 7'b0000000;
    localparam logic [6:0] BAD_OP = 7'b1110011;

    typedef struct packed {
        logic [1:0]       phase;
        logic             rf_we;
        logic             d_mem_we;
        logic             alu_src;
        logic             pc_src;
        logic             rf_src;
        logic [3:0]       alu_cmd;
        logic             illegal;
        logic [CNT_W-1:0] retired;
    } obs_t;

    typedef struct {
        logic       rst;
        logic [6:0] op;
        obs_t       exp;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    control_unit_fsm_if #(.CNT_W(CNT_W)) bus ();

    control_unit_fsm #(.CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int vectors    = 0;
    int miscompares = 0;

    // ---------------- reference model (instruction level) ----------------
    int         m_step;     // position inside the current instruction, 0..3
    bit         m_halt;
    bit         m_illegal;
    int         m_retired;
    logic [6:0] m_op;

    function automatic bit known_op(logic [6:0] op);
        return op inside {R_OP, IA_OP, LD_OP, ST_OP, BR_OP, JAL_OP, BUB_OP};
    endfunction

    task automatic model_edge(input logic r, input logic [6:0] op);
        if (r) begin
            m_step = 0; m_halt = 0; m_illegal = 0; m_retired = 0; m_op = BUB_OP;
        end else if (!m_halt) begin
            if (m_step == 0) begin
                if (!known_op(op)) begin
                    m_halt = 1; m_illegal = 1; m_step = 1;
                end else begin
                    m_op = op; m_step = 1;
                end
            end else if (m_step == 3) begin
                if (m_op != BUB_OP && m_retired < RET_MAX) m_retired++;
                m_op = BUB_OP;
                m_step = 0;
            end else begin
                m_step++;
            end
        end
    endtask

    function automatic obs_t model_out();
        obs_t o;
        bit   wb;
        o = '0;
        o.phase   = 2'(m_step);
        o.illegal = m_illegal;
        o.retired = CNT_W'(m_retired);
        wb = (m_step == 3);
        if (!m_halt && m_step != 0) begin
            case (m_op)
                R_OP:   begin o.alu_cmd = 4'd15; o.rf_we = wb; end
                IA_OP:  begin o.alu_cmd = 4'd15; o.alu_src = 1; o.rf_we = wb; end
                LD_OP:  begin o.alu_src = 1; o.rf_src = 1; o.rf_we = wb; end
                ST_OP:  begin o.alu_src = 1; o.d_mem_we = wb; end
                BR_OP:  begin o.alu_cmd = 4'd1; end
                JAL_OP: begin o.pc_src = 1; end
                default: ;
            endcase
        end
        return o;
    endfunction

    // ---------------- helpers ----------------
    function automatic obs_t sample();
        obs_t o;
        o.phase    = bus.phase;
        o.rf_we    = bus.rf_we;
        o.d_mem_we = bus.d_mem_we;
        o.alu_src  = bus.alu_src;
        o.pc_src   = bus.pc_src;
        o.rf_src   = bus.rf_src;
        o.alu_cmd  = bus.alu_cmd;
        o.illegal  = bus.illegal;
        o.retired  = bus.retired;
        return o;
    endfunction

    function automatic string fmt(obs_t o);
        return $sformatf("ph=%0d rfwe=%0b dwe=%0b asrc=%0b pcs=%0b rfs=%0b cmd=%0d ill=%0b ret=%0d",
                         o.phase, o.rf_we, o.d_mem_we, o.alu_src, o.pc_src, o.rf_src,
                         o.alu_cmd, o.illegal, o.retired);
    endfunction

    task automatic check(input string name, input obs_t exp);
        obs_t got;
        got = sample();
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got {%s} expected {%s}", name, fmt(got), fmt(exp));
        end else begin
            $display("vec %0d %s ok {%s}", vectors, name, fmt(got));
        end
    endtask

    task automatic check_val(input string name, input int got, input int exp);
        vectors++;
        if (got != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end else begin
            $display("vec %0d %s ok value=%0d", vectors, name, got);
        end
    endtask

    // Apply inputs, let one rising edge pass, advance the model, settle.
    task automatic tick(input logic r, input logic [6:0] op);
        rst = r;
        bus.opcode = op;
        @(posedge clk);
        model_edge(r, op);
        #1;
    endtask

    task automatic tick_chk(input string name, input logic r, input logic [6:0] op);
        tick(r, op);
        check(name, model_out());
    endtask

    function automatic vec_t mk(logic r, logic [6:0] op, int ph, bit rfwe, bit dwe,
                                bit asrc, bit pcs, bit rfs, int cmd, bit ill, int ret);
        vec_t v;
        v.rst = r; v.op = op;
        v.exp.phase = 2'(ph); v.exp.rf_we = rfwe; v.exp.d_mem_we = dwe;
        v.exp.alu_src = asrc; v.exp.pc_src = pcs; v.exp.rf_src = rfs;
        v.exp.alu_cmd = 4'(cmd); v.exp.illegal = ill; v.exp.retired = CNT_W'(ret);
        return v;
    endfunction

    vec_t tbl[$];

    initial begin
        int   dwe_seen;
        obs_t o;
        rst = 1'b1;
        bus.opcode = BUB_OP;

        //      rst op      ph we dw as pc rs cmd il ret
        tbl.push_back(mk(1, R_OP,   0, 0, 0, 0, 0, 0,  0, 0, 0));
        tbl.push_back(mk(1, R_OP,   0, 0, 0, 0, 0, 0,  0, 0, 0));
        tbl.push_back(mk(0, R_OP,   1, 0, 0, 0, 0, 0, 15, 0, 0));
        tbl.push_back(mk(0, R_OP,   2, 0, 0, 0, 0, 0, 15, 0, 0));
        tbl.push_back(mk(0, R_OP,   3, 1, 0, 0, 0, 0, 15, 0, 0));
        tbl.push_back(mk(0, R_OP,   0, 0, 0, 0, 0, 0,  0, 0, 1));
        tbl.push_back(mk(0, R_OP,   1, 0, 0, 0, 0, 0, 15, 0, 1));
        tbl.push_back(mk(0, R_OP,   2, 0, 0, 0, 0, 0, 15, 0, 1));
        tbl.push_back(mk(0, LD_OP,  3, 1, 0, 0, 0, 0, 15, 0, 1));
        tbl.push_back(mk(0, LD_OP,  0, 0, 0, 0, 0, 0,  0, 0, 2));
        tbl.push_back(mk(0, LD_OP,  1, 0, 0, 1, 0, 1,  0, 0, 2));
        tbl.push_back(mk(0, R_OP,   2, 0, 0, 1, 0, 1,  0, 0, 2));
        tbl.push_back(mk(0, BAD_OP, 3, 1, 0, 1, 0, 1,  0, 0, 2));
        tbl.push_back(mk(0, ST_OP,  0, 0, 0, 0, 0, 0,  0, 0, 3));
        tbl.push_back(mk(0, ST_OP,  1, 0, 0, 1, 0, 0,  0, 0, 3));
        tbl.push_back(mk(0, BUB_OP, 2, 0, 0, 1, 0, 0,  0, 0, 3));
        tbl.push_back(mk(0, BAD_OP, 3, 0, 1, 1, 0, 0,  0, 0, 3));
        tbl.push_back(mk(0, BUB_OP, 0, 0, 0, 0, 0, 0,  0, 0, 4));

        foreach (tbl[i]) begin
            tick(tbl[i].rst, tbl[i].op);
            check($sformatf("table[%0d]", i), tbl[i].exp);
        end

        // Branch then JAL
        for (int k = 0; k < 4; k++) tick_chk("branch", 0, BR_OP);
        for (int k = 0; k < 4; k++) tick_chk("jal", 0, JAL_OP);
        check_val("jal_pc_src_ph0", int'(bus.pc_src), 0);

        // Three bubbles leave retired unchanged, then an R-type counts
        for (int k = 0; k < 12; k++) tick_chk("bubble", 0, BUB_OP);
        check_val("bubble_retired", int'(bus.retired), 6);
        for (int k = 0; k < 4; k++) tick_chk("r_after_bubble", 0, R_OP);
        check_val("r_after_bubble_retired", int'(bus.retired), 7);

        // Illegal opcode halts; 20 cycles of arbitrary opcodes change nothing
        tick_chk("illegal_sample", 0, BAD_OP);
        check_val("illegal_flag", int'(bus.illegal), 1);
        check_val("illegal_phase", int'(bus.phase), 1);
        for (int k = 0; k < 20; k++) tick_chk("halt_hold", 0, 7'($urandom));
        check_val("halt_retired_frozen", int'(bus.retired), 7);
        tick_chk("halt_reset", 1, R_OP);
        check_val("halt_reset_illegal", int'(bus.illegal), 0);
        check_val("halt_reset_phase", int'(bus.phase), 0);

        // Reset during EX of a store: the write never appears
        tick_chk("st_rst_a", 0, ST_OP);
        tick_chk("st_rst_b", 0, ST_OP);
        tick_chk("st_rst_rst", 1, ST_OP);
        check_val("st_rst_dwe", int'(bus.d_mem_we), 0);
        dwe_seen = 0;
        for (int k = 0; k < 4; k++) begin
            tick_chk("st_rst_after", 0, BUB_OP);
            if (bus.d_mem_we) dwe_seen++;
        end
        check_val("st_rst_no_write", dwe_seen, 0);

        // Saturation of the retired counter
        for (int k = 0; k < 4 * (RET_MAX + 3); k++) tick_chk("saturate", 0, IA_OP);
        check_val("saturate_value", int'(bus.retired), RET_MAX);

        // Randomized opcodes against the model
        tick_chk("rand_reset", 1, BUB_OP);
        for (int k = 0; k < 600; k++) begin
            logic       r;
            logic [6:0] op;
            int         sel;
            r = ($urandom_range(0, 99) < 2) || (m_halt && $urandom_range(0, 9) == 0);
            sel = $urandom_range(0, 19);
            case (sel)
                0, 1, 2:  op = R_OP;
                3, 4:     op = IA_OP;
                5, 6, 7:  op = LD_OP;
                8, 9, 10: op = ST_OP;
                11, 12:   op = BR_OP;
                13, 14:   op = JAL_OP;
                15, 16:   op = BUB_OP;
                default:  op = (sel == 17) ? 7'($urandom) : R_OP;
            endcase
            tick_chk("random", r, op);
        end

        o = sample();
        if (o.illegal === 1'bx) $display("note: illegal unknown at end");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
